// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared types and constants for the multiply/divide issue controller:
//   md_cmd_t      - MD-class command presented by decode
//   MD_OP_*       - MDOp encodings driven to MD
//   MD_WR_*       - MDWrite encodings driven to MD
//   MD_*_LAT      - default MD busy latencies (cycles after the issue edge)
//   lat_ok()      - legal-range test for a latency parameter
// ---------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MFHI  = 4'd7,
        MFLO  = 4'd8
    } md_cmd_t;

    localparam logic [1:0] MD_OP_NONE = 2'b00;
    localparam logic [1:0] MD_OP_MUL  = 2'b01;
    localparam logic [1:0] MD_OP_DIV  = 2'b10;

    localparam logic [1:0] MD_WR_NONE = 2'b00;
    localparam logic [1:0] MD_WR_HI   = 2'b01;
    localparam logic [1:0] MD_WR_LO   = 2'b10;

    localparam int unsigned MD_MUL_LAT = 6;
    localparam int unsigned MD_DIV_LAT = 11;

    // Countdown width is fixed; latencies must fit and be at least 2 so the
    // load value never coincides with the terminal count of 1.
    localparam int CNT_W = 4;

    function automatic logic lat_ok(input int unsigned lat);
        return (lat >= 2) && (lat <= 15);
    endfunction

endpackage

// File: rtl/md_lat_counter.sv
// ---------------------------------------------------------------------------
// md_lat_counter
// Load/decrement countdown modelling how long MD stays busy.
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (count -> 0)
//   load      in   load load_val this edge (has priority over decrement)
//   load_val  in   CNT_W-bit latency to load
//   cnt       out  current count
//   done      out  count is 1: the next edge is the last busy edge
// The counter free-runs down to zero and then holds there.
// ---------------------------------------------------------------------------
module md_lat_counter
    import md_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
// Issue and hazard controller for the E-stage multiply/divide unit (MD).
// Accepts one MD-class instruction per handshake, drives MD's controls,
// tracks MD latency with a private countdown and stalls decode meanwhile.
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   req_valid    in   decode presents an MD-class instruction
//   req_op       in   md_cmd_t command
//   flush        in   kill the presented instruction this cycle
//   md_busy      in   Busy flag from MD, cross-checked against the countdown
//   req_ready    out  instruction accepted this cycle
//   stall        out  freeze decode
//   MDOp         out  00 idle / 01 multiply / 10 divide
//   MDWrite      out  00 none / 01 write HI / 10 write LO
//   CalcuSigned  out  signed multiply/divide
//   rd_valid     out  MFHI/MFLO accepted, HI/LO may be forwarded
//   rd_sel       out  1 = HI, 0 = LO
//   sync_err     out  sticky: md_busy disagreed with the internal state
// All MD controls and rd_* are combinational from the accept decision; MD
// samples them on the accepting edge.
// ---------------------------------------------------------------------------
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned MUL_LAT = MD_MUL_LAT,
    parameter int unsigned DIV_LAT = MD_DIV_LAT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_op,
    input  logic       flush,
    input  logic       md_busy,
    output logic       req_ready,
    output logic       stall,
    output logic [1:0] MDOp,
    output logic [1:0] MDWrite,
    output logic       CalcuSigned,
    output logic       rd_valid,
    output logic       rd_sel,
    output logic       sync_err
);

    if (!lat_ok(MUL_LAT) || !lat_ok(DIV_LAT)) begin : g_bad_lat
        $error("md_issue_ctrl: MUL_LAT and DIV_LAT must lie in 2..15");
    end

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    md_cmd_t          op;
    logic             live;
    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;

    // ---------------------------------------------------------------- decode
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        op          = md_cmd_t'(req_op);
        live        = req_valid & ~flush & (op != NONE);
        accept      = live & (state == IDLE);
        is_mul      = (op == MULT) | (op == MULTU);
        is_div      = (op == DIV)  | (op == DIVU);
        req_ready   = accept;
        // A flushed request is gone, so it never stalls decode.
        stall       = live & ~accept;
        MDOp        = MD_OP_NONE;
        MDWrite     = MD_WR_NONE;
        CalcuSigned = 1'b0;
        rd_valid    = 1'b0;
        rd_sel      = 1'b0;
        if (accept) begin
            unique case (op)
                MULT:  begin MDOp = MD_OP_MUL; CalcuSigned = 1'b1; end
                MULTU: MDOp = MD_OP_MUL;
                DIV:   begin MDOp = MD_OP_DIV; CalcuSigned = 1'b1; end
                DIVU:  MDOp = MD_OP_DIV;
                MTHI:  MDWrite = MD_WR_HI;
                MTLO:  MDWrite = MD_WR_LO;
                MFHI:  begin rd_valid = 1'b1; rd_sel = 1'b1; end
                MFLO:  rd_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign load     = accept & (is_mul | is_div);
    assign load_val = is_div ? DIV_CNT : MUL_CNT;

    // -------------------------------------------------------------- latency
    md_lat_counter u_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .done     (cnt_done)
    );

    // ------------------------------------------------------------------ FSM
    // The counter reaches 0 on the same edge the FSM leaves BUSY, so the
    // two never need an explicit clear. flush is ignored in BUSY: MD cannot
    // abort an operation once it has started.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sync_err <= 1'b0;
        end else begin
            if ((state == BUSY && !md_busy) || (state == IDLE && md_busy)) begin
                sync_err <= 1'b1;
            end
            unique case (state)
                IDLE: if (load)     state <= BUSY;
                BUSY: if (cnt_done) state <= IDLE;
                default:            state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_md_issue_ctrl
// Scoreboard bench for md_issue_ctrl. A driver applies one request per cycle
// and pushes the expected output vector, computed from an abstract model
// (the absolute cycle at which the unit becomes free again), into a queue.
// A monitor pops and compares on every falling edge. A model of MD drives
// md_busy, with an option to drop it for one cycle to provoke sync_err.
// The asynchronous-reset scenario is checked directly at the end.
// ---------------------------------------------------------------------------
module tb_md_issue_ctrl;
    import md_pkg::*;

    localparam int MUL_LAT = 6;
    localparam int DIV_LAT = 11;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_op;
    logic       flush;
    logic       md_busy;
    logic       req_ready;
    logic       stall;
    logic [1:0] MDOp;
    logic [1:0] MDWrite;
    logic       CalcuSigned;
    logic       rd_valid;
    logic       rd_sel;
    logic       sync_err;

    always #5 clk = ~clk;

    md_issue_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .flush       (flush),
        .md_busy     (md_busy),
        .req_ready   (req_ready),
        .stall       (stall),
        .MDOp        (MDOp),
        .MDWrite     (MDWrite),
        .CalcuSigned (CalcuSigned),
        .rd_valid    (rd_valid),
        .rd_sel      (rd_sel),
        .sync_err    (sync_err)
    );

    int errors = 0;
    int checks = 0;

    // Output vector: {req_ready, stall, MDOp, MDWrite, CalcuSigned, rd_valid, rd_sel, sync_err}
    logic [9:0] exp_q[$];

    // Reference model state
    int cyc        = 0;   // index of the cycle being driven
    int free_at    = 0;   // first cycle in which the unit is idle again
    bit err_sticky = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] dut_vec();
        return {req_ready, stall, MDOp, MDWrite, CalcuSigned, rd_valid, rd_sel, sync_err};
    endfunction

    // One cycle of stimulus plus its expected response.
    task automatic drive_cycle(input bit v, input md_cmd_t op, input bit fl, input bit drop_busy);
        bit         busy_now;
        bit         live;
        bit         acc;
        logic [1:0] mop;
        logic [1:0] mwr;
        bit         sgn;
        bit         rv;
        bit         rs;
        @(posedge clk);
        #1;
        busy_now  = (cyc < free_at);
        req_valid = v;
        req_op    = op;
        flush     = fl;
        md_busy   = busy_now && !drop_busy;

        live = v && !fl && (op != NONE);
        acc  = live && !busy_now;
        mop  = !acc ? 2'b00 : (op == MULT || op == MULTU) ? 2'b01 :
               (op == DIV || op == DIVU) ? 2'b10 : 2'b00;
        mwr  = !acc ? 2'b00 : (op == MTHI) ? 2'b01 : (op == MTLO) ? 2'b10 : 2'b00;
        sgn  = acc && (op == MULT || op == DIV);
        rv   = acc && (op == MFHI || op == MFLO);
        rs   = acc && (op == MFHI);
        exp_q.push_back({acc, live && busy_now, mop, mwr, sgn, rv, rs, err_sticky});

        if (md_busy != busy_now) err_sticky = 1'b1;
        if (acc && (op == MULT || op == MULTU)) free_at = cyc + 1 + MUL_LAT;
        if (acc && (op == DIV  || op == DIVU))  free_at = cyc + 1 + DIV_LAT;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, NONE, 1'b0, 1'b0);
    endtask

    // Monitor: compares whatever the scoreboard expects for this cycle.
    initial begin
        logic [9:0] e;
        int         n_mon;
        n_mon = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("sb_cycle%0d", n_mon), 32'(dut_vec()), 32'(e));
                n_mon++;
            end
        end
    end

    initial begin
        int n;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        flush     = 1'b0;
        md_busy   = 1'b0;

        #2;
        check("reset_outputs", 32'(dut_vec()), 32'd0);
        check("reset_cnt", 32'(dut.cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // MULT then MFLO from cycle 2: stalls through cycle 6, accepted in 7.
        drive_cycle(1'b1, MULT, 1'b0, 1'b0);
        idle_cycles(1);
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, MFLO, 1'b0, 1'b0);
        idle_cycles(2);

        // DIVU, then DIV presented from cycle 5: accepted in cycle 12.
        drive_cycle(1'b1, DIVU, 1'b0, 1'b0);
        idle_cycles(4);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, DIV, 1'b0, 1'b0);
        idle_cycles(12);

        // Back-to-back MTHI / MFHI / MTLO / MFLO in IDLE.
        drive_cycle(1'b1, MTHI, 1'b0, 1'b0);
        drive_cycle(1'b1, MFHI, 1'b0, 1'b0);
        drive_cycle(1'b1, MTLO, 1'b0, 1'b0);
        drive_cycle(1'b1, MFLO, 1'b0, 1'b0);

        // Flushed MULTU is dropped, then accepted unflushed.
        drive_cycle(1'b1, MULTU, 1'b1, 1'b0);
        drive_cycle(1'b1, MULTU, 1'b0, 1'b0);
        // Flush during BUSY changes nothing for the countdown.
        drive_cycle(1'b1, DIV, 1'b1, 1'b0);
        idle_cycles(7);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive_cycle($urandom_range(0, 3) != 0,
                        md_cmd_t'(4'($urandom_range(0, 8))),
                        $urandom_range(0, 7) == 0,
                        1'b0);
        end
        idle_cycles(12);

        // md_busy dropped in cycle 3 of a MULT: sync_err sticks afterwards.
        drive_cycle(1'b1, MULT, 1'b0, 1'b0);
        idle_cycles(2);
        drive_cycle(1'b0, NONE, 1'b0, 1'b1);
        idle_cycles(6);
        for (int i = 0; i < 30; i++) begin
            drive_cycle($urandom_range(0, 1) != 0,
                        md_cmd_t'(4'($urandom_range(0, 8))),
                        1'b0, 1'b0);
        end
        idle_cycles(12);

        // Let the monitor drain the scoreboard, within a bound.
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-BUSY.
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op    = DIV;
        flush     = 1'b0;
        md_busy   = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        md_busy   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        req_valid = 1'b1;
        req_op    = MULT;
        #1;
        check("busy_before_reset_stall", 32'({req_ready, stall}), 32'b01);
        reset   = 1'b0;
        md_busy = 1'b0;
        #1;
        check("async_reset_cnt", 32'(dut.cnt), 32'd0);
        check("async_reset_ready", 32'({req_ready, stall}), 32'b10);
        check("async_reset_mdop", 32'(MDOp), 32'b01);
        check("async_reset_sync_err", 32'(sync_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        md_busy = 1'b1;
        #1;
        check("post_reset_mult_busy", 32'({req_ready, stall}), 32'b01);
        check("post_reset_cnt", 32'(dut.cnt), 32'(MUL_LAT));
        check("post_reset_sync_err", 32'(sync_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and hazard controller for the multiply/divide unit (MD) in the E stage. It accepts one MD-class instruction per handshake from decode. For MULT/MULTU/DIV/DIVU/MTHI/MTLO it drives MD's MDOp, MDWrite and CalcuSigned controls. It tracks MD latency with its own countdown and stalls decode while a result is pending. It also checks its timing model against MD's Busy flag.

## Interface
- MUL_LAT, 6: cycles MD stays busy after a multiply issue edge.
- DIV_LAT, 11: cycles MD stays busy after a divide issue edge.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  decode presents an MD-class instruction.
- req_op  in  4  md_cmd_t: NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
- flush  in  1  kill the presented instruction this cycle.
- md_busy  in  1  Busy output of MD.
- req_ready  out  1  instruction accepted this cycle.
- stall  out  1  freeze decode.
- MDOp  out  2  00 idle, 01 multiply, 10 divide; to MD.
- MDWrite  out  2  00 none, 01 write HI, 10 write LO; to MD.
- CalcuSigned  out  1  signed operation; to MD.
- rd_valid  out  1  MFHI/MFLO accepted; HI/LO may be forwarded.
- rd_sel  out  1  1 = HI, 0 = LO.
- sync_err  out  1  sticky mismatch between internal counter and md_busy.

## Operation
- FSM states: IDLE, BUSY. Registered state: state, 4-bit cnt, sync_err.
- accept = req_valid & ~flush & (state==IDLE) & (req_op!=NONE).
- req_ready = accept.
- stall = req_valid & ~flush & (req_op!=NONE) & ~req_ready.
- All MD controls and rd_* are combinational from accept and req_op. They are 0 when accept=0. MD samples them at the accepting edge.
- MULT/MULTU: MDOp=01. CalcuSigned=1 for MULT, 0 for MULTU. Next state BUSY, cnt<=MUL_LAT.
- DIV/DIVU: MDOp=10. CalcuSigned=1 for DIV, 0 for DIVU. Next state BUSY, cnt<=DIV_LAT.
- MTHI: MDWrite=01. MTLO: MDWrite=10. Both stay in IDLE.
- MFHI: rd_valid=1, rd_sel=1. MFLO: rd_valid=1, rd_sel=0. Both stay in IDLE.
- BUSY: cnt decrements each edge. The edge with cnt==1 returns to IDLE with cnt<=0. No request is accepted in BUSY.
- flush has no effect in BUSY. MD cannot abort; the countdown continues.
- sync_err<=1 if md_busy==0 in BUSY, or md_busy==1 in IDLE. Once set it holds until reset.
- LAT parameters must be in 2..15; the width of cnt is fixed at 4 bits.

## Timing
- Reset (reset==0, asynchronous): state=IDLE, cnt=0, sync_err=0. Comb outputs are then 0 unless a request is accepted.
- Issue at edge E0. The controller is in BUSY for exactly LAT cycles after E0. It is IDLE from the cycle after edge E0+LAT.
- That first IDLE cycle coincides with MD's HI/LO update. An MFHI/MFLO accepted in it reads the new value.
- An MD op or MFHI/MFLO presented during BUSY stalls, then is accepted in the first IDLE cycle.
- MTHI/MTLO/MFHI/MFLO in IDLE each take one cycle. Back-to-back acceptance is allowed.
- Reset mid-BUSY aborts the countdown immediately. MD must be reset together with this block.

## Structure
- Package md_pkg holds:
  - md_cmd_t enum;
  - MDOp encodings: MD_OP_NONE, MD_OP_MUL, MD_OP_DIV;
  - MDWrite encodings: MD_WR_NONE, MD_WR_HI, MD_WR_LO;
  - default latencies MD_MUL_LAT and MD_DIV_LAT.
- One sub-module, md_lat_counter: load/decrement countdown with a done flag. The FSM and decode stay in md_issue_ctrl.

## Test plan
- MULT at cycle 0 with req_valid=1 → cycle 0: req_ready=1, MDOp=01, CalcuSigned=1. Cycles 1–6: BUSY. MFLO presented in cycle 2 → stall=1 through cycle 6. Cycle 7: rd_valid=1, rd_sel=0. sync_err stays 0.
- DIVU at cycle 0 → MDOp=10, CalcuSigned=0. req_ready=0 for cycles 1–11. DIV presented at cycle 5 is accepted at cycle 12 with CalcuSigned=1.
- IDLE: MTHI at cycle 0 then MFHI at cycle 1 → MDWrite=01 in cycle 0 only. Cycle 1: rd_valid=1, rd_sel=1. stall=0 throughout.
- MULTU with flush=1 → req_ready=0, MDOp=00, stall=0, state stays IDLE. The same request with flush=0 in the next cycle is accepted.
- DIV issued, reset driven low asynchronously mid-cycle 4 → state=IDLE and cnt=0 before the next edge. After reset release, MULT is accepted on the first edge.
- MULT issued, md_busy forced 0 at cycle 3 → sync_err=1 from edge 3 on. It remains 1 after returning to IDLE and clears only on reset.
